// File: rtl/conv_window_gen_if.sv
// Pixel stream in, flattened multi-channel KxK window out.
// master = pixel producer / window consumer, slave = window generator.
interface conv_window_gen_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IN_CHANNEL  = 3
);
  logic                                                   pixel_valid;
  logic [IN_CHANNEL*DATA_WIDTH-1:0]                       pixel_in;
  logic                                                   window_valid;
  logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multi_channel_window_out;
  logic                                                   frame_done;

  modport master (
    output pixel_valid, pixel_in,
    input  window_valid, multi_channel_window_out, frame_done
  );

  modport slave (
    input  pixel_valid, pixel_in,
    output window_valid, multi_channel_window_out, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator over a raster pixel stream, stride 1, no padding.
// Window bus/valid registered one cycle after the completing pixel; no backpressure.
module conv_window_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IN_CHANNEL  = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic             clk,
  input  logic             rst,
  conv_window_gen_if.slave win_if
);
  localparam int K  = KERNEL_SIZE;
  localparam int PW = IN_CHANNEL * DATA_WIDTH;
  localparam int WB = IN_CHANNEL * K * K * DATA_WIDTH;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  // Line buffer j holds row (row_cnt-(K-1-j)); whole pixel (all channels) per entry.
  logic [PW-1:0] line_buf [K-1][IMG_WIDTH];
  logic [PW-1:0] lb_out   [K-1];
  logic [PW-1:0] win      [K][K];
  logic [PW-1:0] win_nxt  [K][K];
  logic [WB-1:0] win_flat;

  logic accept;
  logic col_last;
  logic row_last;
  logic completing;

  logic          window_valid_q;
  logic [WB-1:0] window_out_q;
  logic          frame_done_q;

  assign accept     = win_if.pixel_valid && !rst;
  assign col_last   = (col_cnt == CW'(IMG_WIDTH - 1));
  assign row_last   = (row_cnt == RW'(IMG_HEIGHT - 1));
  assign completing = accept && (row_cnt >= RW'(K - 1)) && (col_cnt >= CW'(K - 1));

  always_comb begin
    for (int j = 0; j < K - 1; j++) begin
      lb_out[j] = line_buf[j][col_cnt];
    end
  end

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int k = 0; k < K - 1; k++) begin
        win_nxt[r][k] = win[r][k+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_nxt[r][K-1] = lb_out[r];
    end
    win_nxt[K-1][K-1] = win_if.pixel_in;
  end

  // Repack row-major pixels into channel-major (c, r, k) order for the MAC stage.
  always_comb begin
    win_flat = '0;
    for (int c = 0; c < IN_CHANNEL; c++) begin
      for (int r = 0; r < K; r++) begin
        for (int k = 0; k < K; k++) begin
          win_flat[((c*K*K) + (r*K) + k)*DATA_WIDTH +: DATA_WIDTH] =
            win_nxt[r][k][c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Storage only: contents are qualified by the counters, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < K - 2; j++) begin
        line_buf[j][col_cnt] <= line_buf[j+1][col_cnt];
      end
      line_buf[K-2][col_cnt] <= win_if.pixel_in;
      win <= win_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt        <= '0;
      row_cnt        <= '0;
      window_valid_q <= 1'b0;
      window_out_q   <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      window_valid_q <= completing;
      frame_done_q   <= completing && row_last && col_last;
      if (completing) begin
        window_out_q <= win_flat;
      end
      if (accept) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end
  end

  assign win_if.window_valid             = window_valid_q;
  assign win_if.multi_channel_window_out = window_out_q;
  assign win_if.frame_done               = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: expected windows are built from the
// pixel formula p(c,r,k) = r*W + k + 64*c and popped when window_valid appears.
module tb_conv_window_gen;
  localparam int DW = 8;
  localparam int K  = 3;
  localparam int C  = 3;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int PW = C * DW;
  localparam int WB = C * K * K * DW;

  typedef struct packed {
    logic [WB-1:0] w;
    logic          fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_gen_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IN_CHANNEL(C)) bus_if ();

  conv_window_gen #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .IN_CHANNEL(C), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .win_if (bus_if.slave)
  );

  exp_t          q[$];
  logic [WB-1:0] got_wins[$];
  int            got_beat[$];
  logic          got_fd[$];
  int            checks = 0;
  int            errors = 0;
  int            acc_cnt = 0;
  int            br = 0;
  int            bc = 0;
  bit            prev_completes = 1'b0;

  function automatic logic [DW-1:0] pix(int r, int k, int c);
    return DW'(r*W + k + 64*c);
  endfunction

  function automatic logic [WB-1:0] exp_win(int r, int k);
    logic [WB-1:0] w;
    w = '0;
    for (int c = 0; c < C; c++)
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          w[((c*K*K) + i*K + j)*DW +: DW] = pix(r-(K-1)+i, k-(K-1)+j, c);
    return w;
  endfunction

  function automatic int elem(logic [WB-1:0] b, int c, int r, int k);
    return int'(b[((c*K*K) + r*K + k)*DW +: DW]);
  endfunction

  // One clock: score the outputs caused by the previous beat, then drive the next.
  task automatic cycle(input bit v);
    exp_t e;
    @(negedge clk);
    checks++;
    if (bus_if.window_valid !== prev_completes) begin
      errors++;
      $display("FAIL valid_timing got %0b expected %0b after beat %0d",
               bus_if.window_valid, prev_completes, acc_cnt);
    end
    if (bus_if.window_valid === 1'b1) begin
      got_wins.push_back(bus_if.multi_channel_window_out);
      got_beat.push_back(acc_cnt);
      got_fd.push_back(bus_if.frame_done);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got window %h expected none",
                 bus_if.multi_channel_window_out);
      end else begin
        e = q.pop_front();
        if (bus_if.multi_channel_window_out !== e.w) begin
          errors++;
          $display("FAIL window_data got %h expected %h", bus_if.multi_channel_window_out, e.w);
        end
        checks++;
        if (bus_if.frame_done !== e.fd) begin
          errors++;
          $display("FAIL frame_done got %0b expected %0b", bus_if.frame_done, e.fd);
        end
      end
    end else begin
      checks++;
      if (bus_if.frame_done !== 1'b0) begin
        errors++;
        $display("FAIL frame_done_stray got %0b expected 0", bus_if.frame_done);
      end
    end
    bus_if.pixel_valid = v;
    prev_completes = v && (br >= K-1) && (bc >= K-1);
    if (v) begin
      for (int c = 0; c < C; c++) bus_if.pixel_in[c*DW +: DW] = pix(br, bc, c);
      if (prev_completes) q.push_back('{w: exp_win(br, bc), fd: (br == H-1) && (bc == W-1)});
      acc_cnt++;
      if (bc == W-1) begin
        bc = 0;
        br = (br == H-1) ? 0 : br + 1;
      end else begin
        bc++;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    bus_if.pixel_valid = 1'b1;
    bus_if.pixel_in = '1;
    q.delete();
    prev_completes = 1'b0;
    br = 0;
    bc = 0;
    @(negedge clk);
    checks++;
    if (bus_if.window_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b expected 0", bus_if.window_valid);
    end
    checks++;
    if (bus_if.multi_channel_window_out !== '0) begin
      errors++;
      $display("FAIL reset_bus got %h expected 0", bus_if.multi_channel_window_out);
    end
    checks++;
    if (bus_if.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_done got %0b expected 0", bus_if.frame_done);
    end
    rst = 1'b0;
    bus_if.pixel_valid = 1'b0;
  endtask

  task automatic test_continuous(output int s);
    int base;
    int n;
    s = got_wins.size();
    base = acc_cnt;
    for (int i = 0; i < W*H; i++) cycle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    n = got_wins.size() - s;
    checks++;
    if (n != 36) begin
      errors++;
      $display("FAIL cont_count got %0d expected 36", n);
    end
    if (n > 0) begin
      checks++;
      if (got_beat[s] - base != 19) begin
        errors++;
        $display("FAIL cont_first_beat got %0d expected 19", got_beat[s] - base);
      end
      for (int r = 0; r < K; r++)
        for (int k = 0; k < K; k++) begin
          checks++;
          if (elem(got_wins[s], 0, r, k) != r*W + k) begin
            errors++;
            $display("FAIL cont_first_ch0 (%0d,%0d) got %0d expected %0d",
                     r, k, elem(got_wins[s], 0, r, k), r*W + k);
          end
        end
      checks++;
      if (elem(got_wins[s], 2, 0, 0) != 128) begin
        errors++;
        $display("FAIL cont_first_ch2 got %0d expected 128", elem(got_wins[s], 2, 0, 0));
      end
    end
  endtask

  task automatic test_row_boundary;
    int s;
    s = got_wins.size();
    for (int i = 0; i < W*H; i++) cycle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    if (got_wins.size() - s > 6) begin
      // Window 5 comes from pixel (2,7), window 6 from (3,2): beats (3,0),(3,1) give none.
      checks++;
      if (got_beat[s+6] - got_beat[s+5] != 3) begin
        errors++;
        $display("FAIL row_gap got %0d expected 3", got_beat[s+6] - got_beat[s+5]);
      end
      checks++;
      if (elem(got_wins[s+6], 0, 0, 0) != 8) begin
        errors++;
        $display("FAIL row_top_left got %0d expected 8", elem(got_wins[s+6], 0, 0, 0));
      end
      checks++;
      if (elem(got_wins[s+6], 0, 2, 2) != 26) begin
        errors++;
        $display("FAIL row_bottom_right got %0d expected 26", elem(got_wins[s+6], 0, 2, 2));
      end
    end else begin
      checks++;
      errors++;
      $display("FAIL row_count got %0d expected 36", got_wins.size() - s);
    end
  endtask

  task automatic test_random_gaps(input int cs);
    int s;
    int base;
    int n;
    int diff;
    s = got_wins.size();
    base = acc_cnt;
    for (int i = 0; i < 2000 && (acc_cnt - base) < W*H; i++) begin
      if ((acc_cnt - base) == W*H - 1) cycle(1'b1);
      else cycle(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0);
    checks++;
    if (acc_cnt - base != W*H) begin
      errors++;
      $display("FAIL gaps_beats got %0d expected %0d", acc_cnt - base, W*H);
    end
    n = got_wins.size() - s;
    checks++;
    if (n != 36) begin
      errors++;
      $display("FAIL gaps_count got %0d expected 36", n);
    end else begin
      diff = 0;
      for (int i = 0; i < 36; i++) if (got_wins[s+i] !== got_wins[cs+i]) diff++;
      checks++;
      if (diff != 0) begin
        errors++;
        $display("FAIL gaps_vs_continuous got %0d differing windows expected 0", diff);
      end
    end
  endtask

  task automatic test_back_to_back;
    int s;
    int n;
    int nfd;
    s = got_wins.size();
    for (int i = 0; i < 2*W*H; i++) cycle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    n = got_wins.size() - s;
    nfd = 0;
    for (int i = 0; i < n; i++) if (got_fd[s+i]) nfd++;
    checks++;
    if (nfd != 2) begin
      errors++;
      $display("FAIL b2b_frame_done_count got %0d expected 2", nfd);
    end
    checks++;
    if (n != 72) begin
      errors++;
      $display("FAIL b2b_count got %0d expected 72", n);
    end else begin
      checks++;
      if (got_fd[s+35] !== 1'b1 || elem(got_wins[s+35], 0, 2, 2) != 63) begin
        errors++;
        $display("FAIL b2b_last_window got fd=%0b br=%0d expected fd=1 br=63",
                 got_fd[s+35], elem(got_wins[s+35], 0, 2, 2));
      end
      checks++;
      if (got_wins[s+36] !== got_wins[s]) begin
        errors++;
        $display("FAIL b2b_frame2_first got %h expected %h", got_wins[s+36], got_wins[s]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int s;
    int base;
    int n;
    for (int i = 0; i < 30; i++) cycle(1'b1);
    test_reset();
    s = got_wins.size();
    base = acc_cnt;
    for (int i = 0; i < W*H; i++) cycle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    n = got_wins.size() - s;
    checks++;
    if (n != 36) begin
      errors++;
      $display("FAIL rst_mid_count got %0d expected 36", n);
    end
    if (n > 0) begin
      checks++;
      if (got_beat[s] - base != 19) begin
        errors++;
        $display("FAIL rst_mid_first_beat got %0d expected 19", got_beat[s] - base);
      end
      checks++;
      if (got_wins[s] !== exp_win(2, 2)) begin
        errors++;
        $display("FAIL rst_mid_first_window got %h expected %h", got_wins[s], exp_win(2, 2));
      end
    end
  endtask

  initial begin
    int cs;
    rst = 1'b1;
    bus_if.pixel_valid = 1'b0;
    bus_if.pixel_in = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_continuous(cs);
    test_row_boundary();
    test_random_gaps(cs);
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
